// File: rtl/npu_axis_pkg.sv
// Shared definitions for the NPU AXI4-Stream ingress path.
// Contents:
//   axis_in_state_t  - ingress FSM state encoding
//   pack_factor()    - elements packed per SRAM word
//   lane_idx_width() - width of the lane index, never below 1 bit
//   DEF_*            - default parameter values for the ingress block
package npu_axis_pkg;

  localparam int DEF_MAX_ADDR_WIDTH     = 13;
  localparam int DEF_DATA_WIDTH         = 8;
  localparam int DEF_SRAM_WIDTH_I       = 64;
  localparam int DEF_NUM_CHANNELS_WIDTH = $clog2(64 + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } axis_in_state_t;

  function automatic int pack_factor(input int sram_w, input int data_w);
    return sram_w / data_w;
  endfunction

  function automatic int lane_idx_width(input int pack);
    return (pack > 1) ? $clog2(pack) : 1;
  endfunction

endpackage

// File: rtl/axis_word_packer.sv
// Packs stream elements into SRAM-width words, little-endian by lane
// (first element of a word lands in bits [DATA_WIDTH-1:0]).
// Ports:
//   s_axis_aclk / s_axis_aresetn - clock, async active-low reset
//   clear       - drop any partial word and restart at lane 0
//   beat_valid  - an element is accepted this cycle
//   beat_data   - the accepted element
//   beat_last   - the accepted element terminates the transfer
//   packed_word - word as it would be emitted this cycle (includes beat_data)
//   lane_full   - the current lane is the last lane of the word
//   word_emit   - packed_word must be written this cycle
module axis_word_packer
  import npu_axis_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int SRAM_WIDTH_I = DEF_SRAM_WIDTH_I
) (
  input  logic                    s_axis_aclk,
  input  logic                    s_axis_aresetn,
  input  logic                    clear,
  input  logic                    beat_valid,
  input  logic [DATA_WIDTH-1:0]   beat_data,
  input  logic                    beat_last,
  output logic [SRAM_WIDTH_I-1:0] packed_word,
  output logic                    lane_full,
  output logic                    word_emit
);

  localparam int PACK   = pack_factor(SRAM_WIDTH_I, DATA_WIDTH);
  localparam int LANE_W = lane_idx_width(PACK);

  logic [SRAM_WIDTH_I-1:0] lanes_q;
  logic [LANE_W-1:0]       lane_q;

  assign lane_full = (lane_q == LANE_W'(PACK - 1));
  assign word_emit = beat_valid & (lane_full | beat_last);

  // Lanes above lane_q are always zero in lanes_q, so a short final word
  // comes out zero-filled without extra masking.
  always_comb begin
    packed_word = lanes_q;
    for (int i = 0; i < PACK; i++) begin
      if (lane_q == LANE_W'(i)) begin
        packed_word[i*DATA_WIDTH +: DATA_WIDTH] = beat_data;
      end
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      lanes_q <= '0;
      lane_q  <= '0;
    end else if (clear) begin
      lanes_q <= '0;
      lane_q  <= '0;
    end else if (beat_valid) begin
      if (word_emit) begin
        lanes_q <= '0;
        lane_q  <= '0;
      end else begin
        lanes_q <= packed_word;
        lane_q  <= lane_q + LANE_W'(1);
      end
    end
  end

endmodule

// File: rtl/axi_stream_input.sv
// AXI4-Stream slave ingress: receives activation elements, packs them into
// SRAM words written from a programmable base address, then pulses
// input_done and reports beat count, channel count and framing errors.
// Ports:
//   s_axis_aclk / s_axis_aresetn       - clock, async active-low reset
//   s_axis_tdata/tvalid/tready/tlast   - stream slave handshake
//   s_axis_tuser                       - channel count, taken from first beat
//   sram_in_en/addr/data               - single-cycle SRAM write strobe
//   start_input, base_addr, in_size    - transfer arm and setup (IDLE only)
//   input_done                         - one-cycle completion pulse
//   recv_count, recv_channels          - status of last/current transfer
//   err_early_last, err_missing_last   - sticky framing errors
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start_input; tready low
// ST_RECV  | accepting beats; tready high
// ST_FLUSH | final word strobe on the SRAM port; tready low
// ST_DONE  | input_done high for this single cycle
module axi_stream_input
  import npu_axis_pkg::*;
#(
  parameter int MAX_ADDR_WIDTH     = DEF_MAX_ADDR_WIDTH,
  parameter int DATA_WIDTH         = DEF_DATA_WIDTH,
  parameter int SRAM_WIDTH_I       = DEF_SRAM_WIDTH_I,
  parameter int NUM_CHANNELS_WIDTH = DEF_NUM_CHANNELS_WIDTH
) (
  input  logic                          s_axis_aclk,
  input  logic                          s_axis_aresetn,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  input  logic [NUM_CHANNELS_WIDTH-1:0] s_axis_tuser,
  output logic                          sram_in_en,
  output logic [MAX_ADDR_WIDTH-1:0]     sram_in_addr,
  output logic [SRAM_WIDTH_I-1:0]       sram_in_data,
  input  logic                          start_input,
  input  logic [MAX_ADDR_WIDTH-1:0]     base_addr,
  input  logic [MAX_ADDR_WIDTH-1:0]     in_size,
  output logic                          input_done,
  output logic [MAX_ADDR_WIDTH-1:0]     recv_count,
  output logic [NUM_CHANNELS_WIDTH-1:0] recv_channels,
  output logic                          err_early_last,
  output logic                          err_missing_last
);

  axis_in_state_t state_q, state_d;

  logic [MAX_ADDR_WIDTH-1:0] size_q;
  logic [MAX_ADDR_WIDTH-1:0] addr_ptr_q;
  logic [MAX_ADDR_WIDTH:0]   count_inc;
  logic                      start_ok;
  logic                      accept;
  logic                      at_size;
  logic                      term_beat;
  logic                      early_hit;
  logic                      missing_hit;
  logic [SRAM_WIDTH_I-1:0]   packed_word;
  logic                      lane_full;
  logic                      word_emit;

  assign accept = s_axis_tvalid & s_axis_tready;

  // One bit wider than the counter so the size compare cannot alias on wrap.
  assign count_inc   = {1'b0, recv_count} + (MAX_ADDR_WIDTH+1)'(1);
  assign at_size     = (count_inc == {1'b0, size_q});
  assign term_beat   = accept & (s_axis_tlast | at_size);
  assign early_hit   = accept & s_axis_tlast & (count_inc < {1'b0, size_q});
  assign missing_hit = accept & ~s_axis_tlast & at_size;

  axis_word_packer #(
    .DATA_WIDTH   (DATA_WIDTH),
    .SRAM_WIDTH_I (SRAM_WIDTH_I)
  ) u_packer (
    .s_axis_aclk    (s_axis_aclk),
    .s_axis_aresetn (s_axis_aresetn),
    .clear          (start_ok),
    .beat_valid     (accept),
    .beat_data      (s_axis_tdata),
    .beat_last      (term_beat),
    .packed_word    (packed_word),
    .lane_full      (lane_full),
    .word_emit      (word_emit)
  );

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    s_axis_tready = 1'b0;
    input_done    = 1'b0;
    start_ok      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_input) begin
          start_ok = 1'b1;
          state_d  = (in_size == '0) ? ST_DONE : ST_RECV;
        end
      end
      ST_RECV: begin
        s_axis_tready = 1'b1;
        if (term_beat) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        input_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      size_q           <= '0;
      addr_ptr_q       <= '0;
      recv_count       <= '0;
      recv_channels    <= '0;
      err_early_last   <= 1'b0;
      err_missing_last <= 1'b0;
      sram_in_en       <= 1'b0;
      sram_in_addr     <= '0;
      sram_in_data     <= '0;
    end else begin
      sram_in_en   <= 1'b0;
      sram_in_addr <= '0;
      sram_in_data <= '0;

      if (start_ok) begin
        size_q           <= in_size;
        addr_ptr_q       <= base_addr;
        recv_count       <= '0;
        err_early_last   <= 1'b0;
        err_missing_last <= 1'b0;
      end

      if (accept) begin
        recv_count <= count_inc[MAX_ADDR_WIDTH-1:0];
        if (recv_count == '0) begin
          recv_channels <= s_axis_tuser;
        end
        if (early_hit) begin
          err_early_last <= 1'b1;
        end
        if (missing_hit) begin
          err_missing_last <= 1'b1;
        end
      end

      // Address pointer wraps naturally at 2^MAX_ADDR_WIDTH.
      if (word_emit) begin
        sram_in_en   <= 1'b1;
        sram_in_addr <= addr_ptr_q;
        sram_in_data <= packed_word;
        addr_ptr_q   <= addr_ptr_q + MAX_ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_axi_stream_input.sv
module tb_axi_stream_input;

  logic        clk;
  logic        aresetn;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic [6:0]  tuser;
  logic        sram_en;
  logic [12:0] sram_addr;
  logic [63:0] sram_data;
  logic        start_input;
  logic [12:0] base_addr;
  logic [12:0] in_size;
  logic        input_done;
  logic [12:0] recv_count;
  logic [6:0]  recv_channels;
  logic        err_early;
  logic        err_missing;

  int errors = 0;
  int checks = 0;

  axi_stream_input dut (
    .s_axis_aclk      (clk),
    .s_axis_aresetn   (aresetn),
    .s_axis_tdata     (tdata),
    .s_axis_tvalid    (tvalid),
    .s_axis_tready    (tready),
    .s_axis_tlast     (tlast),
    .s_axis_tuser     (tuser),
    .sram_in_en       (sram_en),
    .sram_in_addr     (sram_addr),
    .sram_in_data     (sram_data),
    .start_input      (start_input),
    .base_addr        (base_addr),
    .in_size          (in_size),
    .input_done       (input_done),
    .recv_count       (recv_count),
    .recv_channels    (recv_channels),
    .err_early_last   (err_early),
    .err_missing_last (err_missing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write/done monitor, sampled on the falling edge.
  logic [12:0] wr_addr_q[$];
  logic [63:0] wr_data_q[$];
  int          wr_cyc_q[$];
  int          cyc = 0;
  int          ndone = 0;
  int          done_cyc = 0;
  int          idle_bus_dirty = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (sram_en) begin
      wr_addr_q.push_back(sram_addr);
      wr_data_q.push_back(sram_data);
      wr_cyc_q.push_back(cyc);
    end else if (sram_addr != 13'd0 || sram_data != 64'd0) begin
      idle_bus_dirty = idle_bus_dirty + 1;
    end
    if (input_done) begin
      ndone = ndone + 1;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [12:0] base;
    logic [12:0] size;
    int          nbeats;
    int          last_beat;
    logic [7:0]  first_byte;
    logic [6:0]  tuser;
    bit          gaps;
    int          exp_acc;
    int          exp_writes;
    logic [12:0] exp_first_addr;
    logic [63:0] exp_first_data;
    logic [12:0] exp_last_addr;
    logic [63:0] exp_last_data;
    logic [12:0] exp_count;
    bit          exp_early;
    bit          exp_missing;
    logic [6:0]  exp_chan;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input int id, input vec_t v);
    int wr0, dn0, acc, w, nwr, li;
    bit stop;
    wr0 = wr_addr_q.size();
    dn0 = ndone;
    acc = 0;
    stop = 0;
    @(negedge clk);
    start_input = 1'b1;
    base_addr   = v.base;
    in_size     = v.size;
    @(negedge clk);
    start_input = 1'b0;
    base_addr   = 13'd0;
    in_size     = 13'd0;
    for (int b = 0; b < v.nbeats && !stop; b++) begin
      if (v.gaps && $urandom_range(0, 1) == 1) @(negedge clk);
      tvalid = 1'b1;
      tdata  = v.first_byte + 8'(b);
      tlast  = (b + 1 == v.last_beat);
      tuser  = (b == 0) ? v.tuser : ~v.tuser;
      w = 0;
      while (!tready && w < 8) begin
        @(negedge clk);
        w++;
      end
      if (tready) begin
        acc++;
        @(negedge clk);
      end else begin
        stop = 1;
      end
      tvalid = 1'b0;
      tlast  = 1'b0;
    end
    w = 0;
    while (ndone == dn0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    nwr = wr_addr_q.size() - wr0;
    li  = wr_addr_q.size() - 1;
    $display("vector %0d: accepted=%0d writes=%0d", id, acc, nwr);
    chk("done_pulses", 64'(ndone - dn0), 64'd1);
    chk("accepted_beats", 64'(acc), 64'(v.exp_acc));
    chk("write_count", 64'(nwr), 64'(v.exp_writes));
    if (v.exp_writes > 0 && nwr > 0) begin
      chk("first_addr", 64'(wr_addr_q[wr0]), 64'(v.exp_first_addr));
      chk("first_data", wr_data_q[wr0], v.exp_first_data);
      chk("last_addr", 64'(wr_addr_q[li]), 64'(v.exp_last_addr));
      chk("last_data", wr_data_q[li], v.exp_last_data);
      chk("done_after_flush", 64'(done_cyc), 64'(wr_cyc_q[li] + 1));
    end
    chk("recv_count", 64'(recv_count), 64'(v.exp_count));
    chk("err_early_last", 64'(err_early), 64'(v.exp_early));
    chk("err_missing_last", 64'(err_missing), 64'(v.exp_missing));
    chk("recv_channels", 64'(recv_channels), 64'(v.exp_chan));
  endtask

  initial begin
    int wr0, dn0;

    //        base     size   nb  lb  byte0  tuser  gap acc wr  first addr/data                last addr/data                 cnt    e  m  chan
    vecs[0] = '{13'h010, 13'd16, 16, 16, 8'h00, 7'd5,  0, 16, 2, 13'h010, 64'h0706050403020100, 13'h011, 64'h0F0E0D0C0B0A0908, 13'd16, 0, 0, 7'd5};
    vecs[1] = '{13'h020, 13'd10, 10, 10, 8'h01, 7'd9,  0, 10, 2, 13'h020, 64'h0807060504030201, 13'h021, 64'h0000000000000A09, 13'd10, 0, 0, 7'd9};
    vecs[2] = '{13'h030, 13'd16,  5,  5, 8'h11, 7'd12, 0,  5, 1, 13'h030, 64'h0000001514131211, 13'h030, 64'h0000001514131211, 13'd5,  1, 0, 7'd12};
    vecs[3] = '{13'h040, 13'd4,   6,  0, 8'h21, 7'd64, 0,  4, 1, 13'h040, 64'h0000000024232221, 13'h040, 64'h0000000024232221, 13'd4,  0, 1, 7'd64};
    vecs[4] = '{13'h1FFF,13'd64, 64, 64, 8'h00, 7'd3,  1, 64, 8, 13'h1FFF,64'h0706050403020100, 13'h0006, 64'h3F3E3D3C3B3A3938, 13'd64, 0, 0, 7'd3};
    vecs[5] = '{13'h100, 13'd0,   0,  0, 8'h00, 7'd0,  0,  0, 0, 13'h000, 64'h0,                13'h000, 64'h0,                13'd0,  0, 0, 7'd3};
    vecs[6] = '{13'h050, 13'd8,   8,  8, 8'h40, 7'd1,  0,  8, 1, 13'h050, 64'h4746454443424140, 13'h050, 64'h4746454443424140, 13'd8,  0, 0, 7'd1};

    aresetn     = 1'b0;
    tdata       = 8'd0;
    tvalid      = 1'b0;
    tlast       = 1'b0;
    tuser       = 7'd0;
    start_input = 1'b0;
    base_addr   = 13'd0;
    in_size     = 13'd0;
    repeat (3) @(negedge clk);
    chk("reset_tready", 64'(tready), 64'd0);
    chk("reset_sram_en", 64'(sram_en), 64'd0);
    chk("reset_done", 64'(input_done), 64'd0);
    chk("reset_count", 64'(recv_count), 64'd0);
    aresetn = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_tready", 64'(tready), 64'd0);

    for (int i = 0; i < 7; i++) begin
      run_vec(i, vecs[i]);
    end

    // Zero-size transfer: done on the cycle right after start is taken.
    wr0 = wr_addr_q.size();
    @(negedge clk);
    start_input = 1'b1;
    in_size     = 13'd0;
    base_addr   = 13'h0AA;
    @(negedge clk);
    start_input = 1'b0;
    chk("zero_size_done_high", 64'(input_done), 64'd1);
    @(negedge clk);
    chk("zero_size_done_low", 64'(input_done), 64'd0);
    repeat (2) @(negedge clk);
    chk("zero_size_no_write", 64'(wr_addr_q.size() - wr0), 64'd0);

    // Reset in the middle of a frame after three beats.
    wr0 = wr_addr_q.size();
    dn0 = ndone;
    @(negedge clk);
    start_input = 1'b1;
    base_addr   = 13'h060;
    in_size     = 13'd16;
    @(negedge clk);
    start_input = 1'b0;
    for (int b = 0; b < 3; b++) begin
      tvalid = 1'b1;
      tdata  = 8'h80 + 8'(b);
      tuser  = (b == 0) ? 7'd33 : 7'd0;
      @(negedge clk);
    end
    chk("pre_reset_count", 64'(recv_count), 64'd3);
    chk("pre_reset_chan", 64'(recv_channels), 64'd33);
    aresetn = 1'b0;
    #1;
    chk("abort_tready", 64'(tready), 64'd0);
    chk("abort_count", 64'(recv_count), 64'd0);
    chk("abort_chan", 64'(recv_channels), 64'd0);
    chk("abort_bus", 64'({sram_en, input_done, err_early, err_missing}), 64'd0);
    tvalid = 1'b0;
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_write", 64'(wr_addr_q.size() - wr0), 64'd0);
    chk("abort_no_done", 64'(ndone - dn0), 64'd0);

    run_vec(7, vecs[0]);

    chk("idle_bus_zero", 64'(idle_bus_dirty), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
